// File: rtl/rock_step_sequencer.sv
// Baby-side stepping sequencer: filters the calm indication, decides Flaag/Alaag/Fhoog
// steps and emits registered, glitch-free pulses with guaranteed high and low times.
module rock_step_sequencer #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int PULSE_LEN     = 2,
    parameter int CALM_SAMPLES  = 3,
    parameter int F_MAX         = 5
) (
    input  logic       FclkDff,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       calm_in,
    input  logic [3:0] F,
    input  logic       F0,
    input  logic       AF0,
    output logic       Alaag,
    output logic       Fhoog,
    output logic       Flaag,
    output logic       busy,
    output logic       asleep
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int CW = $clog2(CALM_SAMPLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD  = PW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] CALM_FULL   = CW'(CALM_SAMPLES);
    localparam logic [3:0]    F_CEIL      = 4'(F_MAX);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_EVAL   = 3'd2,
        ST_PULSE  = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TGT_FLAAG = 2'd0,
        TGT_ALAAG = 2'd1,
        TGT_FHOOG = 2'd2
    } tgt_t;

    state_t        state_q, state_d;
    tgt_t          tgt_q, tgt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [CW-1:0] calm_cnt_q, calm_cnt_d;
    logic          abort_pend_q, abort_pend_d;
    logic          alaag_q, alaag_d;
    logic          fhoog_q, fhoog_d;
    logic          flaag_q, flaag_d;
    logic          busy_q, busy_d;
    logic          asleep_q, asleep_d;
    logic          calm_ok;

    assign calm_ok = (calm_cnt_q == CALM_FULL);

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        settle_cnt_d = settle_cnt_q;
        pulse_cnt_d  = pulse_cnt_q;
        abort_pend_d = abort_pend_q;

        if (!calm_in) begin
            calm_cnt_d = '0;
        end else if (calm_cnt_q != CALM_FULL) begin
            calm_cnt_d = calm_cnt_q + CW'(1);
        end else begin
            calm_cnt_d = calm_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (settle_cnt_q == '0) begin
                    state_d = ST_EVAL;
                end else begin
                    settle_cnt_d = settle_cnt_q - SW'(1);
                end
            end
            ST_EVAL: begin
                pulse_cnt_d = PULSE_LOAD;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (calm_ok && !F0) begin
                    state_d = ST_PULSE;
                    tgt_d   = TGT_FLAAG;
                end else if (calm_ok && !AF0) begin
                    state_d = ST_PULSE;
                    tgt_d   = TGT_ALAAG;
                end else if (calm_ok) begin
                    state_d = ST_DONE;
                end else if (F < F_CEIL) begin
                    state_d = ST_PULSE;
                    tgt_d   = TGT_FHOOG;
                end else begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                end
            end
            ST_PULSE: begin
                // abort is only remembered here; the pulse and its gap always run out
                abort_pend_d = abort_pend_q | abort;
                if (pulse_cnt_q == '0) begin
                    state_d     = ST_GAP;
                    pulse_cnt_d = PULSE_LOAD;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PW'(1);
                end
            end
            ST_GAP: begin
                if (pulse_cnt_q == '0) begin
                    abort_pend_d = 1'b0;
                    if (abort_pend_q || abort) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end else begin
                    abort_pend_d = abort_pend_q | abort;
                    pulse_cnt_d  = pulse_cnt_q - PW'(1);
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flaag_d  = (state_d == ST_PULSE) && (tgt_d == TGT_FLAAG);
        alaag_d  = (state_d == ST_PULSE) && (tgt_d == TGT_ALAAG);
        fhoog_d  = (state_d == ST_PULSE) && (tgt_d == TGT_FHOOG);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        asleep_d = (state_d == ST_DONE);
    end

    // State and output registers; reset also cuts any pulse in flight
    always_ff @(posedge FclkDff or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tgt_q        <= TGT_FLAAG;
            settle_cnt_q <= '0;
            pulse_cnt_q  <= '0;
            calm_cnt_q   <= '0;
            abort_pend_q <= 1'b0;
            alaag_q      <= 1'b0;
            fhoog_q      <= 1'b0;
            flaag_q      <= 1'b0;
            busy_q       <= 1'b0;
            asleep_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            settle_cnt_q <= settle_cnt_d;
            pulse_cnt_q  <= pulse_cnt_d;
            calm_cnt_q   <= calm_cnt_d;
            abort_pend_q <= abort_pend_d;
            alaag_q      <= alaag_d;
            fhoog_q      <= fhoog_d;
            flaag_q      <= flaag_d;
            busy_q       <= busy_d;
            asleep_q     <= asleep_d;
        end
    end

    assign Alaag  = alaag_q;
    assign Fhoog  = fhoog_q;
    assign Flaag  = flaag_q;
    assign busy   = busy_q;
    assign asleep = asleep_q;

endmodule

// File: tb/tb_rock_step_sequencer.sv
// Scoreboard bench for rock_step_sequencer: expected pulses are queued by the stimulus,
// a monitor measures each observed pulse and the register-block model reacts to it.
module tb_rock_step_sequencer;
    localparam int SETTLE = 4;
    localparam int PLEN   = 2;
    localparam int PERIOD = SETTLE + 1 + 2 * PLEN;

    localparam logic [2:0] K_FLAAG = 3'b001;
    localparam logic [2:0] K_FHOOG = 3'b010;
    localparam logic [2:0] K_ALAAG = 3'b100;

    logic       FclkDff = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic       calm_in = 1'b0;
    logic [3:0] f_m     = 4'd0;
    int         a_m     = 0;
    logic       Alaag, Fhoog, Flaag, busy, asleep;
    logic       F0, AF0;

    assign F0  = (f_m == 4'd0);
    assign AF0 = (f_m == 4'd0) && (a_m == 0);

    typedef struct {
        logic [2:0] kind;
        int         start_c;
    } exp_t;
    exp_t sb_q[$];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b1;
    logic tog_en = 1'b0;

    rock_step_sequencer #(
        .SETTLE_CYCLES(SETTLE), .PULSE_LEN(PLEN), .CALM_SAMPLES(3), .F_MAX(5)
    ) dut (
        .FclkDff(FclkDff), .reset(reset), .start(start), .abort(abort), .calm_in(calm_in),
        .F(f_m), .F0(F0), .AF0(AF0),
        .Alaag(Alaag), .Fhoog(Fhoog), .Flaag(Flaag), .busy(busy), .asleep(asleep)
    );

    always #5 FclkDff = ~FclkDff;

    always @(posedge FclkDff) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge FclkDff);
    endtask

    task automatic do_start(output int s);
        @(negedge FclkDff);
        start = 1'b1;
        s = cyc + 1;
        @(negedge FclkDff);
        start = 1'b0;
    endtask

    task automatic push(input logic [2:0] kind, input int start_c);
        exp_t e;
        e.kind    = kind;
        e.start_c = start_c;
        sb_q.push_back(e);
    endtask

    // Pulse monitor + register-block model
    initial begin : monitor
        logic [2:0] steps;
        logic [2:0] kind;
        logic       in_pulse;
        int         rise_c;
        int         len;
        int         last_fall;
        exp_t       e;
        in_pulse  = 1'b0;
        kind      = 3'b000;
        rise_c    = 0;
        len       = 0;
        last_fall = -100;
        forever begin
            @(negedge FclkDff);
            steps = {Alaag, Fhoog, Flaag};
            if (reset || !mon_en) begin
                in_pulse = 1'b0;
            end else begin
                if ($countones(steps) > 1) check("onehot", int'(steps), 0);
                if (in_pulse) begin
                    if (steps == kind) begin
                        len++;
                    end else begin
                        in_pulse  = 1'b0;
                        last_fall = cyc;
                        if (sb_q.size() == 0) begin
                            check("unexpected_pulse", int'(kind), 0);
                        end else begin
                            e = sb_q.pop_front();
                            check("pulse_kind", int'(kind), int'(e.kind));
                            check("pulse_start", rise_c, e.start_c);
                            check("pulse_len", len, PLEN);
                        end
                    end
                end
                if (!in_pulse && steps != 3'b000) begin
                    check("gap_ok", int'((cyc - last_fall) >= PLEN), 1);
                    in_pulse = 1'b1;
                    kind     = steps;
                    rise_c   = cyc;
                    len      = 1;
                    if (steps == K_FLAAG && f_m != 4'd0) f_m = f_m - 4'd1;
                    else if (steps == K_ALAAG && a_m != 0) a_m = a_m - 1;
                    else if (steps == K_FHOOG) f_m = f_m + 4'd1;
                end
            end
        end
    end

    // calm_in pattern 1,1,0,0,... so the calm filter never fills
    initial begin : toggler
        int t;
        t = 0;
        forever begin
            @(negedge FclkDff);
            if (tog_en) begin
                calm_in = (t % 4) < 2;
                t++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s;
        repeat (3) @(negedge FclkDff);
        check("rst_busy", int'(busy), 0);
        check("rst_asleep", int'(asleep), 0);
        check("rst_steps", int'({Alaag, Fhoog, Flaag}), 0);
        reset = 1'b0;
        @(negedge FclkDff);
        check("idle_busy", int'(busy), 0);

        // Calm held, F=5, A=5: five Flaag, five Alaag, then asleep
        f_m = 4'd5; a_m = 5; calm_in = 1'b1;
        repeat (4) @(negedge FclkDff);
        do_start(s);
        for (int k = 0; k < 10; k++)
            push((k < 5) ? K_FLAAG : K_ALAAG, s + 5 + PERIOD * k);
        for (int c = s + 1; c <= s + 4 + PERIOD * 10; c++) begin
            wait_until(c);
            if (busy !== 1'b1 || asleep !== 1'b0) check("busy_seq", int'({busy, asleep}), 2);
        end
        check("eval_not_asleep", int'(asleep), 0);
        wait_until(s + 5 + PERIOD * 10);
        check("done_asleep", int'(asleep), 1);
        check("done_busy", int'(busy), 0);
        check("sb_empty_calm", sb_q.size(), 0);
        check("model_a", a_m, 0);

        // start and abort together in DONE: abort wins
        @(negedge FclkDff);
        start = 1'b1; abort = 1'b1;
        @(negedge FclkDff);
        start = 1'b0; abort = 1'b0;
        check("sa_busy", int'(busy), 0);
        check("sa_asleep", int'(asleep), 0);

        // Not calm, F=0: Fhoog; abort on the first pulse cycle keeps pulse and gap
        calm_in = 1'b0;
        do_start(s);
        push(K_FHOOG, s + 5);
        wait_until(s + 5);
        check("fhoog_first", int'(Fhoog), 1);
        abort = 1'b1;
        @(negedge FclkDff);
        abort = 1'b0;
        wait_until(s + 8);
        check("abort_gap_busy", int'(busy), 1);
        wait_until(s + 9);
        check("abort_idle_busy", int'(busy), 0);
        wait_until(s + 30);
        check("sb_empty_abort", sb_q.size(), 0);
        check("abort_idle_late", int'(busy), 0);

        // Toggling calm, F=3: Fhoog until F=5, then SETTLE/EVAL loop without pulses
        f_m = 4'd3;
        tog_en = 1'b1;
        do_start(s);
        push(K_FHOOG, s + 5);
        push(K_FHOOG, s + 5 + PERIOD);
        wait_until(s + 60);
        check("sb_empty_tog", sb_q.size(), 0);
        check("tog_f", int'(f_m), 5);
        check("tog_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge FclkDff);
        abort = 1'b0;
        check("tog_abort_busy", int'(busy), 0);
        tog_en = 1'b0;

        // Reset in the middle of a Flaag pulse
        mon_en = 1'b0;
        f_m = 4'd5; a_m = 5; calm_in = 1'b1;
        repeat (4) @(negedge FclkDff);
        do_start(s);
        wait_until(s + 5);
        check("pre_rst_flaag", int'(Flaag), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_flaag", int'(Flaag), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_asleep", int'(asleep), 0);
        @(negedge FclkDff);
        reset = 1'b0;
        repeat (2) @(negedge FclkDff);
        check("post_rst_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
